vga_undither_12_to_24: RTL and testbench

VGA_UNDITHER_12_TO_24 -- requirements
Module: vga_undither_12_to_24

---
 rtl/vga_undither_12_to_24.sv | 170 +++++++++++++++++
 tb/tb_vga_undither_12_to_24.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_undither_12_to_24.sv
// -----------------------------------------------------------------------------
// vga_undither_12_to_24
//
// Rebuilds a 24-bit colour stream from a 12-bit ordered-dithered VGA stream by
// averaging each pixel with its left, above and above-left neighbours (2x2
// box). The previous scanline is kept in an H_TOTAL-deep line buffer. The
// mean of four 4-bit values is expanded to 8 bits so that 0 maps to 0x00 and
// full scale maps to 0xFF.
//
// Parameters
//   H_TOTAL  total clocks per scanline (blanking included); line-buffer depth
//
// Ports
//   I_clk    in   1   pixel clock, all logic on the rising edge
//   I_reset  in   1   synchronous active-high reset
//   I_vsync  in   1   vertical sync, rising edge starts a frame
//   I_hsync  in   1   horizontal sync, rising edge starts a line
//   I_rgb12  in  12   dithered pixel, R[11:8] G[7:4] B[3:0]
//   O_vsync  out  1   I_vsync delayed by 2 clocks
//   O_hsync  out  1   I_hsync delayed by 2 clocks
//   O_rgb24  out 24   reconstructed pixel, R[23:16] G[15:8] B[7:0]
//
// Stream: no handshake. One pixel is accepted and one produced every clock;
// the pixel presented before edge k appears on O_rgb24 after edge k+1, with
// the syncs delayed identically.
// -----------------------------------------------------------------------------
module vga_undither_12_to_24 #(
    parameter int H_TOTAL = 800
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_vsync,
    input  logic        I_hsync,
    input  logic [11:0] I_rgb12,
    output logic        O_vsync,
    output logic        O_hsync,
    output logic [23:0] O_rgb24
);

    localparam int CW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(H_TOTAL - 1);

    // Sync edge detection and line position
    logic          prev_hsync;
    logic          prev_vsync;
    logic          hs_edge;
    logic          vs_edge;
    logic [CW-1:0] col;
    logic          first_line;

    // Previous scanline; contents deliberately not reset
    logic [11:0]   line_buf [H_TOTAL];

    // Stage A
    logic [11:0]   a_cur;
    logic [11:0]   a_above;
    logic [11:0]   a_left;
    logic [11:0]   a_aboveleft;
    logic          a_col0;
    logic          a_first;

    // Sync delay line
    logic          hs_d1;
    logic          vs_d1;

    // Stage B combinational
    logic [11:0]   b_left;
    logic [11:0]   b_above;
    logic [11:0]   b_aboveleft;
    logic [5:0]    sum;
    logic [23:0]   pix_next;

    assign hs_edge = !prev_hsync && I_hsync;
    assign vs_edge = !prev_vsync && I_vsync;

    // 4->8 expansion of a 4-pixel mean: (sum * 17) / 4. Max 60*17 = 1020
    // fits in 10 bits, so dropping the two LSBs leaves exactly 8 bits.
    function automatic logic [7:0] expand(input logic [5:0] s);
        logic [9:0] p;
        p = 10'(s) * 10'd17;
        return p[9:2];
    endfunction

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            prev_hsync  <= 1'b0;
            prev_vsync  <= 1'b0;
            col         <= '0;
            first_line  <= 1'b1;
            a_cur       <= '0;
            a_left      <= '0;
            a_aboveleft <= '0;
            a_col0      <= 1'b0;
            a_first     <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
            O_hsync     <= 1'b0;
            O_vsync     <= 1'b0;
            O_rgb24     <= '0;
        end else begin
            prev_hsync <= I_hsync;
            prev_vsync <= I_vsync;

            // Column saturates instead of wrapping so an over-long line keeps
            // rewriting the last buffer slot rather than corrupting column 0.
            if (hs_edge) begin
                col <= '0;
            end else if (col != COL_MAX) begin
                col <= col + 1'b1;
            end

            // A vsync edge in the same clock as an hsync edge must win so the
            // line that starts there is treated as the top line.
            if (vs_edge) begin
                first_line <= 1'b1;
            end else if (hs_edge) begin
                first_line <= 1'b0;
            end

            a_cur       <= I_rgb12;
            a_left      <= a_cur;
            a_aboveleft <= a_above;
            a_col0      <= (col == '0);
            a_first     <= first_line;

            hs_d1   <= I_hsync;
            vs_d1   <= I_vsync;
            O_hsync <= hs_d1;
            O_vsync <= vs_d1;
            O_rgb24 <= pix_next;
        end
    end

    // Read-before-write: a_above gets the word the previous line left at this
    // column, then the current pixel replaces it.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            a_above <= '0;
        end else begin
            a_above       <= line_buf[col];
            line_buf[col] <= I_rgb12;
        end
    end

    // Edge substitution: at column 0 there is no left neighbour; on the top
    // line the buffer holds stale data, so the current row stands in for the
    // row above. Column substitution is applied first so the top-left corner
    // collapses to the current pixel.
    always_comb begin
        b_left      = a_left;
        b_above     = a_above;
        b_aboveleft = a_aboveleft;
        sum         = '0;
        pix_next    = '0;
        if (a_col0) begin
            b_left      = a_cur;
            b_aboveleft = a_above;
        end
        if (a_first) begin
            b_above     = a_cur;
            b_aboveleft = b_left;
        end
        for (int ch = 0; ch < 3; ch++) begin
            sum = 6'(a_cur[ch*4 +: 4]) + 6'(b_left[ch*4 +: 4])
                + 6'(b_above[ch*4 +: 4]) + 6'(b_aboveleft[ch*4 +: 4]);
            pix_next[ch*8 +: 8] = expand(sum);
        end
    end

endmodule

// File: tb/tb_vga_undither_12_to_24.sv
// -----------------------------------------------------------------------------
// tb_vga_undither_12_to_24
//
// Self-checking bench for vga_undither_12_to_24 with a small H_TOTAL. Every
// clock the reference model takes the pixel entering the DUT, works out its
// column and top-line status, looks up its neighbours from a record of the
// last pixel written to each column, and pushes the expected output. The
// output is compared one clock later. Directed lines additionally carry a
// fixed expected colour.
// -----------------------------------------------------------------------------
module tb_vga_undither_12_to_24;

    localparam int H = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        hsync;
    logic [11:0] rgb12;
    logic        o_vsync;
    logic        o_hsync;
    logic [23:0] o_rgb24;

    always #5 clk = ~clk;

    vga_undither_12_to_24 #(.H_TOTAL(H)) dut (
        .I_clk   (clk),
        .I_reset (reset),
        .I_vsync (vsync),
        .I_hsync (hsync),
        .I_rgb12 (rgb12),
        .O_vsync (o_vsync),
        .O_hsync (o_hsync),
        .O_rgb24 (o_rgb24)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        known;
        logic [23:0] rgb;
        logic        w_on;
        logic [23:0] w;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "reset";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (%s): got %h expected %h", tag, phase, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [11:0] m_lb  [H];
    bit          m_lbk [H];
    int          m_col;
    bit          m_first;
    bit          m_phs;
    bit          m_pvs;
    logic [11:0] m_prev_pix;
    logic [11:0] m_prev_above;
    bit          m_prev_above_k;

    initial begin
        for (int i = 0; i < H; i++) m_lbk[i] = 1'b0;
    end

    // Average of four 4-bit samples scaled to 8 bits: (s*17)/4 per channel.
    function automatic logic [23:0] blend(input logic [11:0] c, input logic [11:0] l,
                                          input logic [11:0] a, input logic [11:0] d);
        logic [23:0] r;
        int          s;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(c[ch*4 +: 4]) + int'(l[ch*4 +: 4]) + int'(a[ch*4 +: 4]) + int'(d[ch*4 +: 4]);
            r[ch*8 +: 8] = 8'((s * 17) / 4);
        end
        return r;
    endfunction

    task automatic model_edge(input bit rst, input bit hs, input bit vs, input logic [11:0] pix,
                              input bit w_on, input logic [23:0] w_val);
        exp_t        e;
        bit          hse, vse, ak, alk, raw_k;
        logic [11:0] above, left, al, raw_above;
        if (rst) begin
            m_col = 0; m_first = 1'b1; m_phs = 1'b0; m_pvs = 1'b0;
            m_prev_pix = '0; m_prev_above = '0; m_prev_above_k = 1'b1;
            exp_q.delete();
            e = '0;
            e.known = 1'b1;
            exp_q.push_back(e);   // output while reset is applied
            exp_q.push_back(e);   // output from the cleared pipeline
            return;
        end
        hse = !m_phs && hs;
        vse = !m_pvs && vs;
        above = m_lb[m_col];
        ak    = m_lbk[m_col];
        raw_above = above;
        raw_k     = ak;
        left  = m_prev_pix;
        al    = m_prev_above;
        alk   = m_prev_above_k;
        if (m_col == 0) begin
            left = pix; al = above; alk = ak;
        end
        if (m_first) begin
            above = pix; ak = 1'b1; al = left; alk = 1'b1;
        end
        e.vs    = vs;
        e.hs    = hs;
        e.known = ak && alk;
        e.rgb   = blend(pix, left, above, al);
        e.w_on  = w_on;
        e.w     = w_val;
        exp_q.push_back(e);
        m_prev_pix = pix;
        m_prev_above = raw_above;
        m_prev_above_k = raw_k;
        m_lb[m_col]  = pix;
        m_lbk[m_col] = 1'b1;
        if (hse)              m_col = 0;
        else if (m_col < H-1) m_col = m_col + 1;
        if (vse)      m_first = 1'b1;
        else if (hse) m_first = 1'b0;
        m_phs = hs;
        m_pvs = vs;
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit hs, input bit vs, input logic [11:0] pix,
                        input bit w_on, input logic [23:0] w_val);
        exp_t e;
        reset = rst; hsync = hs; vsync = vs; rgb12 = pix;
        @(posedge clk);
        model_edge(rst, hs, vs, pix, w_on, w_val);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sync", 32'({o_vsync, o_hsync}), 32'({e.vs, e.hs}));
            if (e.known) check("rgb", 32'(o_rgb24), 32'(e.rgb));
            if (e.w_on)  check("fixed", 32'(o_rgb24), 32'(e.w));
        end else begin
            check("queue", 32'(0), 32'(1));
        end
    endtask

    // One scanline: hsync high for the first hs_len clocks, vsync pulsed at
    // index vs_at (-1 = none). Pixel index i >= 1 lands in column i-1.
    // mode 0: even columns get a, odd columns b; mode 1: random pixels.
    task automatic drive_line(input int len, input int hs_len, input int vs_at, input int mode,
                              input logic [11:0] a, input logic [11:0] b,
                              input bit w_on, input logic [23:0] w0, input logic [23:0] w1);
        int          c;
        logic [11:0] p;
        for (int i = 0; i < len; i++) begin
            c = i - 1;
            if (mode == 1)   p = 12'($urandom);
            else if (i == 0) p = b;
            else             p = (c % 2 == 0) ? a : b;
            step(1'b0, i < hs_len, i == vs_at, p, w_on && (i >= 1), (c == 0) ? w0 : w1);
        end
    endtask

    task automatic reset_burst(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom), 1'($urandom), 12'($urandom), 1'b0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len, hl, va;

        phase = "reset";
        reset_burst(6);

        phase = "const_fff";
        drive_line(12, 3, 0, 0, 12'hFFF, 12'hFFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
        drive_line(12, 3, -1, 0, 12'hFFF, 12'hFFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF);

        phase = "const_888";
        drive_line(12, 2, 0, 0, 12'h888, 12'h888, 1'b1, 24'h888888, 24'h888888);
        drive_line(12, 2, -1, 0, 12'h888, 12'h888, 1'b1, 24'h888888, 24'h888888);

        phase = "first_line_alt";
        drive_line(12, 3, 0, 0, 12'h000, 12'hFFF, 1'b1, 24'h000000, 24'h7F7F7F);

        phase = "checkerboard";
        drive_line(12, 3, 0, 0, 12'h777, 12'h888, 1'b0, '0, '0);
        drive_line(12, 3, -1, 0, 12'h888, 12'h777, 1'b1, 24'h7F7F7F, 24'h7F7F7F);

        phase = "saturate";
        drive_line(H + 6, 2, -1, 1, '0, '0, 1'b0, '0, '0);
        drive_line(10, 2, -1, 1, '0, '0, 1'b0, '0, '0);
        drive_line(10, 2, 0, 0, 12'hFFF, 12'hFFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF);

        phase = "mid_line_reset";
        drive_line(7, 2, -1, 1, '0, '0, 1'b0, '0, '0);
        reset_burst(2);
        drive_line(9, 1, -1, 1, '0, '0, 1'b0, '0, '0);
        drive_line(9, 1, -1, 1, '0, '0, 1'b0, '0, '0);

        phase = "random";
        for (int n = 0; n < 200; n++) begin
            len = $urandom_range(4, H + 3);
            hl  = $urandom_range(1, 3);
            case ($urandom_range(0, 7))
                0:       va = 0;
                1:       va = $urandom_range(1, len - 1);
                default: va = -1;
            endcase
            if ($urandom_range(0, 19) == 0) reset_burst($urandom_range(1, 3));
            drive_line(len, hl, va, 1, '0, '0, 1'b0, '0, '0);
        end
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
